// File: rtl/ad4003_emulator.sv
// Fabric model of one AD4003 serial port: timed conversion on CNV, MSB-first readout on SDO,
// and the 16-bit register-write command on SDI with an optional 6-bit status trailer.
module ad4003_emulator #(
  parameter int unsigned ADC_DATA_WIDTH = 18,
  parameter int unsigned CONV_CYCLES    = 30,
  parameter logic [7:0]  CONFIG_RESET   = 8'hE1
) (
  input  logic                      clk_100,
  input  logic                      reset_n,
  input  logic                      cnv_in,
  input  logic                      sck_in,
  input  logic                      sdi_in,
  input  logic [ADC_DATA_WIDTH-1:0] sample_data,
  output logic                      sdo,
  output logic                      busy,
  output logic [7:0]                config_reg,
  output logic                      frame_done,
  output logic                      conv_overrun
);

  localparam int unsigned FrameMax = ADC_DATA_WIDTH + 6;
  localparam int unsigned CntW     = $clog2(CONV_CYCLES + 1);
  localparam int unsigned BitW     = $clog2(FrameMax + 1);
  localparam logic [7:0]  WriteCmd = 8'h14;
  localparam logic [4:0]  SdiFull  = 5'd16;

  typedef enum logic [1:0] {StIdle, StConv, StRead} state_e;

  state_e state_q, state_d;

  // Pin synchronizers and edge detection.
  logic [1:0] cnv_sync_q, sck_sync_q, sdi_sync_q;
  logic       cnv_prev_q, sck_prev_q;
  logic       cnv_rise, sck_rise, sck_fall, sdi_s;

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      cnv_sync_q <= '0;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cnv_prev_q <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      cnv_sync_q <= {cnv_sync_q[0], cnv_in};
      sck_sync_q <= {sck_sync_q[0], sck_in};
      sdi_sync_q <= {sdi_sync_q[0], sdi_in};
      cnv_prev_q <= cnv_sync_q[1];
      sck_prev_q <= sck_sync_q[1];
    end
  end

  assign cnv_rise = cnv_sync_q[1] & ~cnv_prev_q;
  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
  assign sdi_s    = sdi_sync_q[1];

  // Datapath state.
  logic [CntW-1:0]           conv_cnt_q, conv_cnt_d;
  logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [ADC_DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [15:0]               sdi_shift_q, sdi_shift_d;
  logic [4:0]                sdi_cnt_q, sdi_cnt_d;
  logic                      sdo_bit_q, sdo_bit_d;
  logic                      done_ev_q, done_ev_d;
  logic                      ovr_ev_q, ovr_ev_d;
  logic                      wr_ev_q, wr_ev_d;
  logic [7:0]                wr_data_q, wr_data_d;

  // Output stage, one cycle behind the FSM decisions.
  logic       sdo_q, frame_done_q, conv_overrun_q;
  logic [7:0] config_q;

  logic [FrameMax-1:0] frame_vec;
  logic [BitW-1:0]     frame_len;
  logic [BitW-1:0]     frame_idx;
  logic                frame_bit;

  assign frame_vec = {shadow_q, config_q[5:0]};
  assign frame_len = config_q[4] ? BitW'(FrameMax) : BitW'(ADC_DATA_WIDTH);
  assign frame_idx = BitW'(FrameMax - 1) - bit_cnt_q;
  assign frame_bit = frame_vec[frame_idx];

  // State register.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cnv_rise) state_d = StConv;
      StConv:  if (conv_cnt_q == '0) state_d = StRead;
      StRead:  if (cnv_rise) state_d = StConv;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values and output decisions.
  always_comb begin
    conv_cnt_d  = conv_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shadow_d    = shadow_q;
    sdi_shift_d = sdi_shift_q;
    sdi_cnt_d   = sdi_cnt_q;
    sdo_bit_d   = sdo_bit_q;
    wr_data_d   = wr_data_q;
    done_ev_d   = 1'b0;
    ovr_ev_d    = 1'b0;
    wr_ev_d     = 1'b0;
    busy        = (state_q == StConv);
    unique case (state_q)
      StIdle: begin
        if (cnv_rise) begin
          shadow_d   = sample_data;
          conv_cnt_d = CntW'(CONV_CYCLES - 1);
        end
      end
      StConv: begin
        ovr_ev_d = cnv_rise;
        if (conv_cnt_q == '0) begin
          sdo_bit_d = shadow_q[ADC_DATA_WIDTH-1];
          bit_cnt_d = BitW'(1);
        end else begin
          conv_cnt_d = conv_cnt_q - 1'b1;
        end
      end
      StRead: begin
        // CNV wins over any SCK edge flagged in the same cycle.
        if (cnv_rise) begin
          done_ev_d = 1'b1;
          if (sdi_cnt_q == SdiFull && sdi_shift_q[15:8] == WriteCmd) begin
            wr_ev_d   = 1'b1;
            wr_data_d = sdi_shift_q[7:0];
          end
          sdi_cnt_d  = '0;
          shadow_d   = sample_data;
          conv_cnt_d = CntW'(CONV_CYCLES - 1);
          sdo_bit_d  = 1'b0;
          bit_cnt_d  = '0;
        end else begin
          if (sck_fall) begin
            if (bit_cnt_q < frame_len) begin
              sdo_bit_d = frame_bit;
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
              sdo_bit_d = 1'b0;
            end
          end
          if (sck_rise) begin
            sdi_shift_d = {sdi_shift_q[14:0], sdi_s};
            if (sdi_cnt_q != SdiFull) sdi_cnt_d = sdi_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        sdo_bit_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      conv_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shadow_q    <= '0;
      sdi_shift_q <= '0;
      sdi_cnt_q   <= '0;
      sdo_bit_q   <= 1'b0;
      done_ev_q   <= 1'b0;
      ovr_ev_q    <= 1'b0;
      wr_ev_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      conv_cnt_q  <= conv_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shadow_q    <= shadow_d;
      sdi_shift_q <= sdi_shift_d;
      sdi_cnt_q   <= sdi_cnt_d;
      sdo_bit_q   <= sdo_bit_d;
      done_ev_q   <= done_ev_d;
      ovr_ev_q    <= ovr_ev_d;
      wr_ev_q     <= wr_ev_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Output registers: SDO and the write commit land four cycles after the pin edge.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      sdo_q          <= 1'b0;
      frame_done_q   <= 1'b0;
      conv_overrun_q <= 1'b0;
      config_q       <= CONFIG_RESET;
    end else begin
      sdo_q          <= sdo_bit_q;
      frame_done_q   <= done_ev_q;
      conv_overrun_q <= ovr_ev_q;
      if (wr_ev_q) config_q <= wr_data_q;
    end
  end

  assign sdo          = sdo_q;
  assign frame_done   = frame_done_q;
  assign conv_overrun = conv_overrun_q;
  assign config_reg   = config_q;

endmodule
